nvme_sq_issue: RTL and testbench

Builds NVMe I/O submission queue entries (SQEs) and writes them into the Tx buffer as 4 x 128-bit beats. It then pulses a tail-doorbell request for the target SQ.
- Allocates the command identifier cmd_id = {req_id, action_id, sq_index} in the same order the completion tracker expects.
- Limits outstanding commands per action_id to TRACK_NUM, so tracking slots never overflow.
- Credits are returned by the tracker's update-done handshake.

---
 rtl/nvme_sq_issue_pkg.sv | 44 ++++
 rtl/nvme_sqe_pack.sv | 40 ++++
 rtl/nvme_sq_issue.sv | 245 ++++++++++++++++++++++++
 tb/tb_nvme_sq_issue.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvme_sq_issue_pkg.sv
// nvme_sq_issue_pkg: definitions shared by the SQ issue block and the completion tracker.
//   - Command id field widths, the per-action outstanding limit and the req_id width.
//   - SQE dword offsets, which fix where each field lands inside the 128-bit beats.
//   - The cmd_id packing struct and a helper that widens it to the 16-bit NVMe CID.
// Build-time macros (defaults apply when they are not given on the command line):
//   TRACK_NUM, CMD_ACTION_ID_BITS, CMD_QUEUE_ID_BITS.
`ifndef TRACK_NUM
`define TRACK_NUM 8
`endif
`ifndef CMD_ACTION_ID_BITS
`define CMD_ACTION_ID_BITS 4
`endif
`ifndef CMD_QUEUE_ID_BITS
`define CMD_QUEUE_ID_BITS 4
`endif

package nvme_sq_issue_pkg;
    localparam int CMD_ACTION_ID_BITS = `CMD_ACTION_ID_BITS;
    localparam int CMD_QUEUE_ID_BITS  = `CMD_QUEUE_ID_BITS;
    localparam int TRACK_NUM          = `TRACK_NUM;
    localparam int REQ_ID_BITS        = (TRACK_NUM > 1) ? $clog2(TRACK_NUM) : 1;
    // Credit counters must be able to hold TRACK_NUM itself.
    localparam int CREDIT_BITS        = $clog2(TRACK_NUM + 1);

    // SQE dword offsets; beat k carries dwords 4k..4k+3.
    localparam int SQE_DW_CDW0  = 0;
    localparam int SQE_DW_NSID  = 1;
    localparam int SQE_DW_PRP1  = 6;
    localparam int SQE_DW_PRP2  = 8;
    localparam int SQE_DW_SLBA  = 10;
    localparam int SQE_DW_CDW12 = 12;

    // cmd_id layout, LSB first: sq_index, action_id, req_id. The tracker decodes
    // CQE DW3 with the same struct, so field order must not change.
    typedef struct packed {
        logic [REQ_ID_BITS-1:0]        req_id;
        logic [CMD_ACTION_ID_BITS-1:0] action_id;
        logic [CMD_QUEUE_ID_BITS-1:0]  sq_index;
    } cmd_id_t;

    function automatic logic [15:0] cmd_id_to_cid(input cmd_id_t id);
        return 16'(id);
    endfunction
endpackage

// File: rtl/nvme_sqe_pack.sv
// nvme_sqe_pack: combinational mapping of a beat index plus command fields onto
// one 128-bit Tx buffer word of an NVMe submission queue entry.
// Ports: i_beat (0..3), i_cid, i_opcode, i_nsid, i_prp1, i_prp2, i_slba, i_nlb -> o_word.
module nvme_sqe_pack
    import nvme_sq_issue_pkg::*;
(
    input  logic [1:0]   i_beat,
    input  logic [15:0]  i_cid,
    input  logic [7:0]   i_opcode,
    input  logic [31:0]  i_nsid,
    input  logic [63:0]  i_prp1,
    input  logic [63:0]  i_prp2,
    input  logic [63:0]  i_slba,
    input  logic [15:0]  i_nlb,
    output logic [127:0] o_word
);
    // Place each field at its dword offset within the selected beat.
    always_comb begin
        o_word = 128'h0;
        case (i_beat)
            2'd0: begin
                o_word[(SQE_DW_CDW0 % 4) * 32 +: 32] = {i_cid, 8'h00, i_opcode};
                o_word[(SQE_DW_NSID % 4) * 32 +: 32] = i_nsid;
            end
            2'd1: begin
                o_word[(SQE_DW_PRP1 % 4) * 32 +: 64] = i_prp1;
            end
            2'd2: begin
                o_word[(SQE_DW_PRP2 % 4) * 32 +: 64] = i_prp2;
                o_word[(SQE_DW_SLBA % 4) * 32 +: 64] = i_slba;
            end
            2'd3: begin
                o_word[(SQE_DW_CDW12 % 4) * 32 +: 16] = i_nlb;
            end
            default: begin
                o_word = 128'h0;
            end
        endcase
    end
endmodule

// File: rtl/nvme_sq_issue.sv
// nvme_sq_issue: accepts I/O commands, writes each SQE to the Tx buffer as four
// 128-bit beats, then raises a one-cycle tail-doorbell request for its SQ.
// Ports: cmd_* request channel (cmd_ready combinational); tx_* buffer writes;
// sq_tail_* doorbell request; sq_head_* head updates from the completion path;
// track_update_* credit returns; issue_error sticky credit-underflow flag.
// Optional macro NVME_SQ_ISSUE_STATS_EN adds issue_count and credit_stall.
module nvme_sq_issue
    import nvme_sq_issue_pkg::*;
#(
    parameter int TX_ADDR_BITS  = 10,
    parameter int SQ_DEPTH_BITS = 4
) (
    input  logic                          axi_aclk,
    input  logic                          axi_areset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [CMD_ACTION_ID_BITS-1:0] cmd_action_id,
    input  logic [CMD_QUEUE_ID_BITS-1:0]  cmd_sq_index,
    input  logic [7:0]                    cmd_opcode,
    input  logic [31:0]                   cmd_nsid,
    input  logic [63:0]                   cmd_prp1,
    input  logic [63:0]                   cmd_prp2,
    input  logic [63:0]                   cmd_slba,
    input  logic [15:0]                   cmd_nlb,
    output logic                          tx_write_valid,
    output logic [TX_ADDR_BITS-1:0]       tx_waddr,
    output logic [127:0]                  tx_wdata,
    output logic                          sq_tail_valid,
    output logic [CMD_QUEUE_ID_BITS-1:0]  sq_tail_index,
    output logic [SQ_DEPTH_BITS-1:0]      sq_tail_value,
    input  logic                          sq_head_valid,
    input  logic [CMD_QUEUE_ID_BITS-1:0]  sq_head_index,
    input  logic [SQ_DEPTH_BITS-1:0]      sq_head_value,
    input  logic                          track_update_done,
    input  logic [CMD_ACTION_ID_BITS-1:0] track_update_id,
    input  logic [1:0]                    track_update_data,
    output logic                          issue_error
`ifdef NVME_SQ_ISSUE_STATS_EN
    ,
    output logic [31:0]                   issue_count,
    output logic                          credit_stall
`endif
);
    localparam int ACT_W  = CMD_ACTION_ID_BITS;
    localparam int QID_W  = CMD_QUEUE_ID_BITS;
    localparam int NUM_ACT = 1 << ACT_W;
    localparam int NUM_SQ  = 1 << QID_W;

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, BEAT2, BEAT3, RING} state_t;

    state_t                   r_state;
    logic [SQ_DEPTH_BITS-1:0] r_tail    [NUM_SQ];
    logic [SQ_DEPTH_BITS-1:0] r_head    [NUM_SQ];
    logic [REQ_ID_BITS-1:0]   r_req_ctr [NUM_ACT];
    logic [CREDIT_BITS-1:0]   r_credit  [NUM_ACT];
    logic [CREDIT_BITS-1:0]   w_credit_nxt [NUM_ACT];

    logic [ACT_W-1:0]         r_act;
    logic [QID_W-1:0]         r_sq;
    logic [REQ_ID_BITS-1:0]   r_req_id;
    logic [SQ_DEPTH_BITS-1:0] r_cur_tail;
    logic [7:0]               r_opcode;
    logic [31:0]              r_nsid;
    logic [63:0]              r_prp1;
    logic [63:0]              r_prp2;
    logic [63:0]              r_slba;
    logic [15:0]              r_nlb;
    logic                     r_tx_valid;
    logic                     r_db_valid;
    logic [QID_W-1:0]         r_db_index;
    logic [SQ_DEPTH_BITS-1:0] r_db_value;
    logic                     r_error;

    logic                     w_ready;
    logic                     w_accept;
    logic                     w_ret;
    logic                     w_ret_err;
    logic [1:0]               w_beat;
    logic [SQ_DEPTH_BITS-1:0] w_tail_next;
    logic [127:0]             w_wdata;
    logic                     w_unused_trk;

    // Full when advancing the tail would collide with the head (one slot kept empty).
    assign w_ready  = (r_state == IDLE) && !axi_areset
                   && (r_credit[cmd_action_id] < CREDIT_BITS'(TRACK_NUM))
                   && ((r_tail[cmd_sq_index] + SQ_DEPTH_BITS'(1)) != r_head[cmd_sq_index]);
    assign w_accept = cmd_valid && w_ready;
    assign w_ret    = track_update_done && track_update_data[0];
    assign w_unused_trk = track_update_data[1];
    assign w_tail_next  = r_cur_tail + SQ_DEPTH_BITS'(1);

    // Next credit count per action: an accept and a return on the same action cancel.
    always_comb begin
        w_ret_err = 1'b0;
        for (int a = 0; a < NUM_ACT; a++) begin
            w_credit_nxt[a] = r_credit[a];
            if (w_accept && (cmd_action_id == ACT_W'(a))) begin
                if (!(w_ret && (track_update_id == ACT_W'(a)))) begin
                    w_credit_nxt[a] = r_credit[a] + CREDIT_BITS'(1);
                end else begin
                    w_credit_nxt[a] = r_credit[a];
                end
            end else if (w_ret && (track_update_id == ACT_W'(a))) begin
                if (r_credit[a] == CREDIT_BITS'(0)) begin
                    w_ret_err = 1'b1;
                end else begin
                    w_credit_nxt[a] = r_credit[a] - CREDIT_BITS'(1);
                end
            end else begin
                w_credit_nxt[a] = r_credit[a];
            end
        end
    end

    // Beat index follows the FSM state.
    always_comb begin
        case (r_state)
            BEAT0:   w_beat = 2'd0;
            BEAT1:   w_beat = 2'd1;
            BEAT2:   w_beat = 2'd2;
            BEAT3:   w_beat = 2'd3;
            default: w_beat = 2'd0;
        endcase
    end

    nvme_sqe_pack u_pack (
        .i_beat   (w_beat),
        .i_cid    (cmd_id_to_cid(cmd_id_t'{req_id: r_req_id, action_id: r_act, sq_index: r_sq})),
        .i_opcode (r_opcode),
        .i_nsid   (r_nsid),
        .i_prp1   (r_prp1),
        .i_prp2   (r_prp2),
        .i_slba   (r_slba),
        .i_nlb    (r_nlb),
        .o_word   (w_wdata)
    );

    // Issue FSM plus the per-SQ and per-action bookkeeping it owns.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_state    <= IDLE;
            r_act      <= '0;
            r_sq       <= '0;
            r_req_id   <= '0;
            r_cur_tail <= '0;
            r_opcode   <= 8'h00;
            r_nsid     <= 32'h0;
            r_prp1     <= 64'h0;
            r_prp2     <= 64'h0;
            r_slba     <= 64'h0;
            r_nlb      <= 16'h0;
            r_tx_valid <= 1'b0;
            r_db_valid <= 1'b0;
            r_db_index <= '0;
            r_db_value <= '0;
            r_error    <= 1'b0;
            for (int s = 0; s < NUM_SQ; s++) begin
                r_tail[s] <= '0;
                r_head[s] <= '0;
            end
            for (int a = 0; a < NUM_ACT; a++) begin
                r_req_ctr[a] <= '0;
                r_credit[a]  <= '0;
            end
        end else begin
            for (int a = 0; a < NUM_ACT; a++) begin
                r_credit[a] <= w_credit_nxt[a];
            end
            if (w_ret_err) begin
                r_error <= 1'b1;
            end
            if (sq_head_valid) begin
                r_head[sq_head_index] <= sq_head_value;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_act      <= cmd_action_id;
                        r_sq       <= cmd_sq_index;
                        r_req_id   <= r_req_ctr[cmd_action_id];
                        r_cur_tail <= r_tail[cmd_sq_index];
                        r_opcode   <= cmd_opcode;
                        r_nsid     <= cmd_nsid;
                        r_prp1     <= cmd_prp1;
                        r_prp2     <= cmd_prp2;
                        r_slba     <= cmd_slba;
                        r_nlb      <= cmd_nlb;
                        r_req_ctr[cmd_action_id] <=
                            (r_req_ctr[cmd_action_id] == REQ_ID_BITS'(TRACK_NUM - 1))
                            ? '0 : r_req_ctr[cmd_action_id] + REQ_ID_BITS'(1);
                        r_tx_valid <= 1'b1;
                        r_state    <= BEAT0;
                    end
                end
                BEAT0: r_state <= BEAT1;
                BEAT1: r_state <= BEAT2;
                BEAT2: r_state <= BEAT3;
                BEAT3: begin
                    r_tx_valid   <= 1'b0;
                    r_tail[r_sq] <= w_tail_next;
                    r_db_valid   <= 1'b1;
                    r_db_index   <= r_sq;
                    r_db_value   <= w_tail_next;
                    r_state      <= RING;
                end
                RING: begin
                    r_db_valid <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_db_valid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready      = w_ready;
    assign tx_write_valid = r_tx_valid;
    assign tx_waddr       = TX_ADDR_BITS'({r_sq, r_cur_tail, w_beat});
    assign tx_wdata       = w_wdata;
    assign sq_tail_valid  = r_db_valid;
    assign sq_tail_index  = r_db_index;
    assign sq_tail_value  = r_db_value;
    assign issue_error    = r_error;

`ifdef NVME_SQ_ISSUE_STATS_EN
    logic [31:0] r_issue_count;

    // Accepted-command counter, free-running with natural wrap.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_issue_count <= 32'h0;
        end else if (w_accept) begin
            r_issue_count <= r_issue_count + 32'd1;
        end else begin
            r_issue_count <= r_issue_count;
        end
    end

    assign issue_count  = r_issue_count;
    assign credit_stall = (r_state == IDLE) && !axi_areset && cmd_valid && !w_ready;
`endif
endmodule

// File: tb/tb_nvme_sq_issue.sv
module tb_nvme_sq_issue;
    import nvme_sq_issue_pkg::*;

    localparam int AW  = CMD_ACTION_ID_BITS;
    localparam int QW  = CMD_QUEUE_ID_BITS;
    localparam int DB  = 4;
    localparam int TXA = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           axi_areset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [AW-1:0]  cmd_action_id = '0;
    logic [QW-1:0]  cmd_sq_index = '0;
    logic [7:0]     cmd_opcode = 8'h00;
    logic [31:0]    cmd_nsid = 32'h0;
    logic [63:0]    cmd_prp1 = 64'h0;
    logic [63:0]    cmd_prp2 = 64'h0;
    logic [63:0]    cmd_slba = 64'h0;
    logic [15:0]    cmd_nlb = 16'h0;
    logic           tx_write_valid;
    logic [TXA-1:0] tx_waddr;
    logic [127:0]   tx_wdata;
    logic           sq_tail_valid;
    logic [QW-1:0]  sq_tail_index;
    logic [DB-1:0]  sq_tail_value;
    logic           sq_head_valid = 1'b0;
    logic [QW-1:0]  sq_head_index = '0;
    logic [DB-1:0]  sq_head_value = '0;
    logic           track_update_done = 1'b0;
    logic [AW-1:0]  track_update_id = '0;
    logic [1:0]     track_update_data = 2'b00;
    logic           issue_error;

    nvme_sq_issue #(.TX_ADDR_BITS(TXA), .SQ_DEPTH_BITS(DB)) dut (
        .axi_aclk(clk), .axi_areset(axi_areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_action_id(cmd_action_id), .cmd_sq_index(cmd_sq_index),
        .cmd_opcode(cmd_opcode), .cmd_nsid(cmd_nsid), .cmd_prp1(cmd_prp1),
        .cmd_prp2(cmd_prp2), .cmd_slba(cmd_slba), .cmd_nlb(cmd_nlb),
        .tx_write_valid(tx_write_valid), .tx_waddr(tx_waddr), .tx_wdata(tx_wdata),
        .sq_tail_valid(sq_tail_valid), .sq_tail_index(sq_tail_index),
        .sq_tail_value(sq_tail_value),
        .sq_head_valid(sq_head_valid), .sq_head_index(sq_head_index),
        .sq_head_value(sq_head_value),
        .track_update_done(track_update_done), .track_update_id(track_update_id),
        .track_update_data(track_update_data), .issue_error(issue_error)
    );

    typedef struct {
        logic [AW-1:0] act;
        logic [QW-1:0] sq;
        logic [7:0]    op;
        logic [31:0]   nsid;
        logic [63:0]   prp1;
        logic [63:0]   prp2;
        logic [63:0]   slba;
        logic [15:0]   nlb;
    } vec_t;

    typedef struct {
        vec_t v;
        int   exp_req;
        int   exp_tail;
    } tab_t;

    typedef struct {
        logic [TXA-1:0] addr;
        logic [127:0]   data;
    } beat_t;

    typedef struct {
        logic [QW-1:0] idx;
        logic [DB-1:0] val;
    } db_t;

    beat_t q_beat[$];
    db_t   q_db[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    m_tail [16];
    int    m_head [16];
    int    m_req  [16];
    int    m_cred [16];

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [127:0] exp_beat(input int k, input vec_t v, input int req);
        logic [15:0] cid;
        cid = (16'(req) << (AW + QW)) | (16'(v.act) << QW) | 16'(v.sq);
        case (k)
            0:       return {64'h0, v.nsid, cid, 8'h00, v.op};
            1:       return {v.prp1, 64'h0};
            2:       return {v.slba, v.prp2};
            default: return {112'h0, v.nlb};
        endcase
    endfunction

    function automatic logic [TXA-1:0] exp_addr(input vec_t v, input int tail, input int k);
        return TXA'({v.sq, 4'(tail), 2'(k)});
    endfunction

    // Scoreboard: every Tx write and doorbell is matched against the queued expectation.
    always @(negedge clk) begin
        if (tx_write_valid === 1'b1) begin
            if (q_beat.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL tx_unexpected: write at addr %0h, none expected", tx_waddr);
            end else begin
                beat_t b;
                b = q_beat.pop_front();
                check("tx_waddr", 128'(tx_waddr), 128'(b.addr));
                check("tx_wdata", tx_wdata, b.data);
            end
        end
        if (sq_tail_valid === 1'b1) begin
            if (q_db.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL db_unexpected: doorbell sq %0d value %0d, none expected", sq_tail_index, sq_tail_value);
            end else begin
                db_t d;
                d = q_db.pop_front();
                check("sq_tail_index", 128'(sq_tail_index), 128'(d.idx));
                check("sq_tail_value", 128'(sq_tail_value), 128'(d.val));
            end
        end
    end

    task automatic drive_cmd(input vec_t v);
        cmd_action_id = v.act; cmd_sq_index = v.sq; cmd_opcode = v.op;
        cmd_nsid = v.nsid; cmd_prp1 = v.prp1; cmd_prp2 = v.prp2;
        cmd_slba = v.slba; cmd_nlb = v.nlb; cmd_valid = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: cmd_ready %b after 100 cycles, expected 1", name, cmd_ready);
        end
    endtask

    // Present a command, wait for acceptance, queue its beats/doorbell, update the model.
    task automatic issue(input vec_t v, input int req, input int tail, input bit with_ret, input string name);
        drive_cmd(v);
        wait_ready(name);
        if (with_ret) begin
            track_update_done = 1'b1; track_update_id = v.act; track_update_data = 2'b01;
        end
        for (int k = 0; k < 4; k++) begin
            q_beat.push_back('{addr: exp_addr(v, tail, k), data: exp_beat(k, v, req)});
        end
        q_db.push_back('{idx: v.sq, val: DB'(tail + 1)});
        m_req[v.act] = (req == TRACK_NUM - 1) ? 0 : req + 1;
        m_tail[v.sq] = (tail + 1) % 16;
        if (!with_ret) m_cred[v.act]++;
        @(posedge clk); #1;
        cmd_valid = 1'b0; track_update_done = 1'b0; track_update_data = 2'b00;
    endtask

    task automatic send(input vec_t v, input bit with_ret, input string name);
        issue(v, m_req[v.act], m_tail[v.sq], with_ret, name);
    endtask

    task automatic wait_idle();
        repeat (7) @(posedge clk);
        #1;
    endtask

    task automatic expect_stall(input string name, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            check(name, 128'(cmd_ready), 128'(1'b0));
        end
    endtask

    task automatic pulse_ret(input logic [AW-1:0] id, input logic [1:0] data);
        track_update_done = 1'b1; track_update_id = id; track_update_data = data;
        @(posedge clk); #1;
        track_update_done = 1'b0; track_update_data = 2'b00;
    endtask

    function automatic vec_t mk(input int act, input int sq, input int op, input int seed);
        vec_t v;
        v.act = AW'(act); v.sq = QW'(sq); v.op = 8'(op);
        v.nsid = 32'(seed + 1);
        v.prp1 = {32'hA000_0000 + 32'(seed), 32'h1000};
        v.prp2 = {32'hB000_0000 + 32'(seed), 32'h2000};
        v.slba = {32'h0, 32'hC000_0000 + 32'(seed)};
        v.nlb  = 16'(seed * 3 + 7);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab_t tab [6];
        vec_t v;
        logic [31:0] lo;
        for (int i = 0; i < 16; i++) begin
            m_tail[i] = 0; m_head[i] = 0; m_req[i] = 0; m_cred[i] = 0;
        end
        tab[0] = '{v: mk(0, 0, 8'h01, 10), exp_req: 0, exp_tail: 0};
        tab[1] = '{v: mk(0, 0, 8'h02, 11), exp_req: 1, exp_tail: 1};
        tab[2] = '{v: mk(7, 5, 8'h02, 12), exp_req: 0, exp_tail: 0};
        tab[3].v = '{act: 4'hF, sq: 4'hF, op: 8'hFF, nsid: 32'hFFFF_FFFF,
                     prp1: 64'hFFFF_FFFF_FFFF_FFFF, prp2: 64'hFFFF_FFFF_FFFF_FFFF,
                     slba: 64'hFFFF_FFFF_FFFF_FFFF, nlb: 16'hFFFF};
        tab[3].exp_req = 0; tab[3].exp_tail = 0;
        tab[4] = '{v: mk(0, 5, 8'h01, 14), exp_req: 2, exp_tail: 1};
        tab[5] = '{v: mk(3, 2, 8'h01, 15), exp_req: 1, exp_tail: 1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 128'(cmd_ready), 128'(1'b0));
        check("rst_tx_write_valid", 128'(tx_write_valid), 128'(1'b0));
        check("rst_sq_tail_valid", 128'(sq_tail_valid), 128'(1'b0));
        check("rst_issue_error", 128'(issue_error), 128'(1'b0));
        @(posedge clk); #1;
        axi_areset = 1'b0;
        @(negedge clk);
        check("idle_tx_waddr", 128'(tx_waddr), 128'(0));
        check("idle_tx_wdata", tx_wdata, 128'(0));
        check("idle_tail_value", 128'(sq_tail_value), 128'(0));
        check("idle_cmd_ready", 128'(cmd_ready), 128'(1'b1));
        @(posedge clk); #1;

        // Single command: action 3, SQ 2, opcode 02, nsid 1
        v = mk(3, 2, 8'h02, 0);
        send(v, 1'b0, "single_accept");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("single_tx_valid", 128'(tx_write_valid), 128'(1'b1));
            check("single_tx_addr", 128'(tx_waddr), 128'(128 + k));
            if (k == 0) begin
                lo = tx_wdata[31:0];
                check("single_cdw0", 128'(lo), 128'(32'h0032_0002));
            end
        end
        @(negedge clk);
        check("single_db_valid", 128'(sq_tail_valid), 128'(1'b1));
        check("single_db_value", 128'(sq_tail_value), 128'(1));
        wait_idle();

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            issue(tab[i].v, tab[i].exp_req, tab[i].exp_tail, 1'b0, "table_accept");
        end
        wait_idle();

        // Credit exhaustion on action 5
        for (int i = 0; i < TRACK_NUM; i++) send(mk(5, 3, 8'h01, 20 + i), 1'b0, "credit_accept");
        wait_idle();
        drive_cmd(mk(5, 3, 8'h01, 40));
        expect_stall("credit_block", 3);
        pulse_ret(4'd5, 2'b01);
        m_cred[5]--;
        send(mk(5, 3, 8'h01, 40), 1'b0, "credit_resume");
        wait_idle();

        // Fill SQ 1, then head update releases the stalled entry
        for (int i = 0; i < 15; i++) send(mk((i % 2 == 1) ? 9 : 8, 1, 8'h02, 50 + i), 1'b0, "sqfill_accept");
        wait_idle();
        drive_cmd(mk(10, 1, 8'h02, 70));
        expect_stall("sq_full_block", 3);
        sq_head_valid = 1'b1; sq_head_index = 4'd1; sq_head_value = 4'd4;
        @(posedge clk); #1;
        sq_head_valid = 1'b0;
        send(mk(10, 1, 8'h02, 70), 1'b0, "sq_full_resume");
        wait_idle();

        // Same-cycle accept and return on action 2 at outstanding 7
        for (int i = 0; i < 7; i++) send(mk(2, 4, 8'h01, 80 + i), 1'b0, "same_fill");
        pulse_ret(4'd2, 2'b10);
        wait_idle();
        send(mk(2, 4, 8'h01, 90), 1'b1, "same_cycle");
        wait_idle();
        send(mk(2, 4, 8'h01, 91), 1'b0, "same_after");
        wait_idle();
        drive_cmd(mk(2, 4, 8'h01, 92));
        expect_stall("same_limit", 3);
        cmd_valid = 1'b0;
        wait_idle();

        // Credit underflow sets a sticky error
        pulse_ret(4'd14, 2'b01);
        @(negedge clk);
        check("underflow_err", 128'(issue_error), 128'(1'b1));
        repeat (5) @(posedge clk);
        #1;
        pulse_ret(4'd0, 2'b00);
        @(negedge clk);
        check("underflow_sticky", 128'(issue_error), 128'(1'b1));
        @(posedge clk); #1;

        // Reset while the third beat is on the bus
        v = mk(11, 6, 8'h02, 100);
        drive_cmd(v);
        wait_ready("rst_mid_accept");
        for (int k = 0; k < 3; k++) begin
            q_beat.push_back('{addr: exp_addr(v, m_tail[6], k), data: exp_beat(k, v, m_req[11])});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        axi_areset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_tx_valid", 128'(tx_write_valid), 128'(1'b0));
        check("rst_mid_err_clear", 128'(issue_error), 128'(1'b0));
        @(posedge clk); #1;
        axi_areset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_tail[i] = 0; m_head[i] = 0; m_req[i] = 0; m_cred[i] = 0;
        end
        repeat (8) begin
            @(negedge clk);
            check("rst_mid_no_db", 128'(sq_tail_valid), 128'(1'b0));
        end
        @(posedge clk); #1;
        send(mk(5, 3, 8'h03, 110), 1'b0, "post_rst_accept");
        wait_idle();

        check("beat_queue_empty", 128'(q_beat.size()), 128'(0));
        check("db_queue_empty", 128'(q_db.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
